// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_FIFO_DEPTH_DEF = 16;

  // Pointer width carries one extra wrap bit to tell full from empty
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the empty flag masks stale contents
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with sticky overrun flag.
// Optional registered almost_full_o output when UART_RX_FIFO_ALMOST_FULL_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH_DEF
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AFULL_THRESH = DEPTH - 2
`endif
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic [DATA_W-1:0]      rx_data_i,
  input  logic                   rx_done_i,
  output logic [DATA_W-1:0]      m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overrun_o,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  output logic                   almost_full_o,
`endif
  input  logic                   overrun_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          rx_done_q;
  logic          push_req, push_ok, pop;

  // The receiver holds done high for a whole byte time, so only its rising edge counts
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done_i;
    end
  end

  assign push_req = rx_done_i & ~rx_done_q;

  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level_o   = wr_ptr - rd_ptr;
  assign m_valid_o = ~empty_o;

  // A pop in the same cycle frees the slot the new byte lands in, so full plus pop still accepts
  assign pop     = m_valid_o & m_ready_i;
  assign push_ok = push_req & (~full_o | pop);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A fresh overrun outranks a clear requested in the same cycle
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      overrun_o <= 1'b0;
    end else if (push_req && full_o && !pop) begin
      overrun_o <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(rx_data_i),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(m_data_o)
  );

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic [PW-1:0] level_nxt;

  assign level_nxt = (wr_ptr + PW'(push_ok)) - (rd_ptr + PW'(pop));

  // Looks one cycle ahead so RTS logic reacts as the level crosses the threshold
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      almost_full_o <= 1'b0;
    end else begin
      almost_full_o <= (int'(level_nxt) >= AFULL_THRESH);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued at push time, compared at pop time.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [4:0] level;
  logic       full, empty, overrun;
  logic       overrun_clr = 1'b0;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .rx_data_i    (rx_data),
    .rx_done_i    (rx_done),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .level_o      (level),
    .full_o       (full),
    .empty_o      (empty),
    .overrun_o    (overrun),
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    .almost_full_o(almost_full),
`endif
    .overrun_clr_i(overrun_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_level(input string name, input logic [4:0] want);
    tests_run++;
    if (level !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: level got %0d, expected %0d", name, level, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] data);
    rx_data = data;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(data);
    tick();
  endtask

  task automatic pop_check(input string name);
    logic [7:0] want;
    int waited = 0;
    while (!m_valid && waited < 4) begin
      tick();
      waited++;
    end
    tests_run++;
    if (!m_valid || exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: valid got %b with %0d bytes expected", name, m_valid, exp_q.size());
      return;
    end
    want = exp_q.pop_front();
    if (m_data !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: data got %02h, expected %02h", name, m_data, want);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) pop_check(name);
    check_bit({name, "_empty"}, empty, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    check_bit("rst_empty", empty, 1'b1);
    check_bit("rst_full", full, 1'b0);
    check_bit("rst_valid", m_valid, 1'b0);
    check_bit("rst_overrun", overrun, 1'b0);
    check_level("rst_level", 5'd0);
    rx_data = 8'h5A;
    rx_done = 1'b1;
    tick();
    nreset = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    tick();
    rx_done = 1'b0;
    check_level("done_at_reset_level", 5'd1);
    drain("done_at_reset");
  endtask

  task automatic test_single();
    rx_data = 8'hA5;
    rx_done = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    check_bit("single_valid", m_valid, 1'b1);
    check_level("single_level", 5'd1);
    rx_done = 1'b0;
    tick();
    drain("single");
  endtask

  task automatic test_held_done();
    rx_data = 8'h3C;
    rx_done = 1'b1;
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 50; i++) tick();
    rx_done = 1'b0;
    tick();
    check_level("held_level", 5'd1);
    drain("held");
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check_bit("fill_full", full, 1'b1);
    check_bit("fill_no_overrun", overrun, 1'b0);
    push_byte(8'hFF);
    check_bit("fill_overrun", overrun, 1'b1);
    check_level("fill_level", 5'd16);
    drain("fill_drain");
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check_bit("fill_clr", overrun, 1'b0);
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] want;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    check_bit("simul_full", full, 1'b1);
    want = exp_q.pop_front();
    tests_run++;
    if (m_data !== want) begin
      tests_failed++;
      $display("[TB] FAIL simul_head: data got %02h, expected %02h", m_data, want);
    end
    rx_data = 8'h77;
    rx_done = 1'b1;
    m_ready = 1'b1;
    tick();
    exp_q.push_back(8'h77);
    m_ready = 1'b0;
    rx_done = 1'b0;
    check_level("simul_level", 5'd16);
    check_bit("simul_overrun", overrun, 1'b0);
    tick();
    drain("simul_drain");
  endtask

  task automatic test_overrun_clear_race();
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
    rx_data = 8'hEE;
    rx_done = 1'b1;
    overrun_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    overrun_clr = 1'b0;
    check_bit("race_set_wins", overrun, 1'b1);
    tick();
    check_bit("race_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check_bit("race_clear", overrun, 1'b0);
    drain("race_drain");
  endtask

  task automatic test_async_reset_and_wrap();
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    check_level("arst_level_before", 5'd5);
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    exp_q.delete();
    check_bit("arst_empty", empty, 1'b1);
    check_bit("arst_valid", m_valid, 1'b0);
    check_level("arst_level", 5'd0);
    #2;
    nreset = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i * 7 + 3));
      pop_check("wrap");
    end
    check_bit("wrap_empty", empty, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_held_done();
    test_fill_overrun();
    test_full_simultaneous();
    test_overrun_clear_race();
    test_async_reset_and_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
